// File: rtl/encoder_layer_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : encoder_layer_sequencer_pkg                                     |
// | Brief    : Shared transformer definitions: default sizes and the           |
// |            sequencer state encoding.                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package encoder_layer_sequencer_pkg;

    localparam int c_DATA_W     = 16;
    localparam int c_SEQ_LEN    = 30;
    localparam int c_NUM_LAYERS = 6;
    localparam int c_SEL_W      = 3;

    // Sequencer state encoding
    localparam int             c_ST_W    = 3;
    localparam logic [2:0]     c_ST_IDLE = 3'd0;
    localparam logic [2:0]     c_ST_LOAD = 3'd1;
    localparam logic [2:0]     c_ST_FEED = 3'd2;
    localparam logic [2:0]     c_ST_WAIT = 3'd3;
    localparam logic [2:0]     c_ST_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/encoder_layer_sequencer_token_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : token_bank                                                      |
// | Brief    : SEQ_LEN x DATA_W token register file. One write port, one       |
// |            registered read port, full flattened view, async clear.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module token_bank
    import encoder_layer_sequencer_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int SEQ_LEN = c_SEQ_LEN,
    parameter int IDX_W   = $clog2(c_SEQ_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_we,
    input  logic [IDX_W-1:0]          i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [IDX_W-1:0]          i_raddr,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [SEQ_LEN*DATA_W-1:0] o_flat
);

    logic [DATA_W-1:0] r_mem [SEQ_LEN];
    logic [DATA_W-1:0] r_rdata;

    // Token storage and registered read; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

    // Token i occupies bits [i*DATA_W +: DATA_W] of the flat view
    for (genvar g = 0; g < SEQ_LEN; g++) begin : g_flat
        assign o_flat[g*DATA_W +: DATA_W] = r_mem[g];
    end

endmodule
`default_nettype wire

// File: rtl/encoder_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : encoder_layer_sequencer                                         |
// | Brief    : Time-multiplexes one encoder over NUM_LAYERS passes using two  |
// |            ping-pong token banks, then presents the flattened result.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module encoder_layer_sequencer
    import encoder_layer_sequencer_pkg::*;
#(
    parameter int DATA_W     = c_DATA_W,
    parameter int SEQ_LEN    = c_SEQ_LEN,
    parameter int NUM_LAYERS = c_NUM_LAYERS,
    parameter int SEL_W      = c_SEL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         enc_data,
    output logic                      enc_valid,
    output logic [SEL_W-1:0]          enc_block_sel,
    input  logic [DATA_W-1:0]         enc_out,
    input  logic                      enc_out_valid,
    output logic [SEQ_LEN*DATA_W-1:0] flat_data,
    output logic                      flat_valid,
    input  logic                      flat_ack,
    output logic                      busy,
    output logic                      err
);

    localparam int IDX_W = $clog2(SEQ_LEN);
    // Feed counter needs one extra bit so it can hold SEQ_LEN itself
    localparam int CNT_W = IDX_W + 1;

    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(SEQ_LEN - 1);
    localparam logic [SEL_W-1:0] c_SEL_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_SEL_FINAL = SEL_W'(NUM_LAYERS - 1);

    logic [c_ST_W-1:0]  r_state;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   r_col_idx;
    logic [CNT_W-1:0]   r_fed;       // tokens issued to the encoder this layer
    logic [SEL_W-1:0]   r_layer;
    logic               r_cur;       // bank holding the current layer's input
    logic               r_in_ready;
    logic               r_enc_valid;
    logic [SEL_W-1:0]   r_enc_sel;
    logic               r_flat_valid;
    logic               r_err;

    logic                      w_load;
    logic                      w_col_ok;
    logic                      w_col_last;
    logic                      w_err_beat;
    logic                      w_we0;
    logic                      w_we1;
    logic [IDX_W-1:0]          w_waddr0;
    logic [DATA_W-1:0]         w_wdata0;
    logic [DATA_W-1:0]         w_rdata0;
    logic [DATA_W-1:0]         w_rdata1;
    logic [SEQ_LEN*DATA_W-1:0] w_flat0;
    logic [SEQ_LEN*DATA_W-1:0] w_flat1;

    // in_ready is only ever high in IDLE/LOAD, so it qualifies loading on its own
    assign w_load = in_valid && r_in_ready;

    // A result is legal only while collecting and only for a token already issued;
    // this also catches an extra beat arriving just after a layer wrapped
    assign w_col_ok   = enc_out_valid
                        && ((r_state == c_ST_FEED) || (r_state == c_ST_WAIT))
                        && ({1'b0, r_col_idx} < r_fed);
    assign w_col_last = w_col_ok && (r_col_idx == c_IDX_LAST);
    assign w_err_beat = enc_out_valid && !w_col_ok;

    // Bank 0 receives input tokens during load; results go to the non-current bank
    assign w_we0    = w_load || (w_col_ok && r_cur);
    assign w_we1    = w_col_ok && !r_cur;
    assign w_waddr0 = w_load ? r_wr_idx : r_col_idx;
    assign w_wdata0 = w_load ? in_data  : enc_out;

    token_bank #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN),
        .IDX_W   (IDX_W)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we0),
        .i_waddr (w_waddr0),
        .i_wdata (w_wdata0),
        .i_raddr (r_fed[IDX_W-1:0]),
        .o_rdata (w_rdata0),
        .o_flat  (w_flat0)
    );

    token_bank #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN),
        .IDX_W   (IDX_W)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we1),
        .i_waddr (r_col_idx),
        .i_wdata (enc_out),
        .i_raddr (r_fed[IDX_W-1:0]),
        .o_rdata (w_rdata1),
        .o_flat  (w_flat1)
    );

    // Sequencer FSM with counters, registered outputs and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_wr_idx     <= '0;
            r_col_idx    <= '0;
            r_fed        <= '0;
            r_layer      <= '0;
            r_cur        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_enc_valid  <= 1'b0;
            r_enc_sel    <= '0;
            r_flat_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_enc_valid <= 1'b0;
            if (w_err_beat) begin
                r_err <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_load) begin
                        r_wr_idx <= r_wr_idx + c_IDX_ONE;
                        r_state  <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (w_load) begin
                        if (r_wr_idx == c_IDX_LAST) begin
                            r_wr_idx   <= '0;
                            r_layer    <= '0;
                            r_cur      <= 1'b0;
                            r_fed      <= '0;
                            r_col_idx  <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= c_ST_FEED;
                        end else begin
                            r_wr_idx <= r_wr_idx + c_IDX_ONE;
                        end
                    end
                end
                c_ST_FEED: begin
                    r_enc_valid <= 1'b1;
                    r_enc_sel   <= r_layer;
                    r_fed       <= r_fed + c_CNT_ONE;
                    if (r_fed == c_CNT_LAST) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_DONE: begin
                    if (flat_ack) begin
                        r_flat_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // Result collection; completing a layer flips the banks and picks the next pass
            if (w_col_ok) begin
                if (w_col_last) begin
                    r_col_idx <= '0;
                    r_cur     <= !r_cur;
                    r_layer   <= r_layer + c_SEL_ONE;
                    r_fed     <= '0;
                    if (r_layer == c_SEL_FINAL) begin
                        r_state      <= c_ST_DONE;
                        r_flat_valid <= 1'b1;
                    end else begin
                        r_state <= c_ST_FEED;
                    end
                end else begin
                    r_col_idx <= r_col_idx + c_IDX_ONE;
                end
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign enc_valid     = r_enc_valid;
    assign enc_block_sel = r_enc_sel;
    assign enc_data      = r_enc_valid ? (r_cur ? w_rdata1 : w_rdata0) : '0;
    assign flat_data     = r_cur ? w_flat1 : w_flat0;
    assign flat_valid    = r_flat_valid;
    assign busy          = (r_state != c_ST_IDLE);
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_encoder_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_encoder_layer_sequencer                                      |
// | Brief    : Self-checking bench: random token sequences, behavioural        |
// |            encoder model and layer-sum reference for the flat result.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_encoder_layer_sequencer;

    localparam int DW = 16;
    localparam int SL = 30;
    localparam int NL = 2;
    localparam int SW = 3;
    // Each pass adds (layer+1), so the total offset is 1+2+...+NL
    localparam int c_SUM = NL * (NL + 1) / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     enc_data;
    logic              enc_valid;
    logic [SW-1:0]     enc_block_sel;
    logic [DW-1:0]     enc_out;
    logic              enc_out_valid;
    logic [SL*DW-1:0]  flat_data;
    logic              flat_valid;
    logic              flat_ack;
    logic              busy;
    logic              err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] tok [SL];
    int  load_idx, n_beats, n_rsp, last_rsp;
    bit  loading, gap, fv_seen, inject31, inject_next, inject_load, junk_in;
    int            q_due [$];
    logic [DW-1:0] q_val [$];

    encoder_layer_sequencer #(
        .DATA_W     (DW),
        .SEQ_LEN    (SL),
        .NUM_LAYERS (NL),
        .SEL_W      (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .enc_data      (enc_data),
        .enc_valid     (enc_valid),
        .enc_block_sel (enc_block_sel),
        .enc_out       (enc_out),
        .enc_out_valid (enc_out_valid),
        .flat_data     (flat_data),
        .flat_valid    (flat_valid),
        .flat_ack      (flat_ack),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_in_ready",   64'(in_ready), 64'd0);
        chk("rst_enc_valid",  64'(enc_valid), 64'd0);
        chk("rst_enc_data",   64'(enc_data), 64'd0);
        chk("rst_enc_sel",    64'(enc_block_sel), 64'd0);
        chk("rst_flat_zero",  64'(flat_data == '0), 64'd1);
        chk("rst_flat_valid", 64'(flat_valid), 64'd0);
        chk("rst_busy",       64'(busy), 64'd0);
        chk("rst_err",        64'(err), 64'd0);
    endtask

    task automatic check_flat();
        for (int i = 0; i < SL; i++) begin
            logic [DW-1:0] e;
            e = tok[i] + DW'(c_SUM);
            chk($sformatf("flat[%0d]", i), 64'(flat_data[i*DW +: DW]), 64'(e));
        end
    endtask

    // One clock: sample DUT after the edge, update the models, drive next inputs
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (enc_valid) begin
            int lyr, k;
            logic [DW-1:0] e;
            lyr = n_beats / SL;
            k   = n_beats % SL;
            e   = tok[k] + DW'(lyr * (lyr + 1) / 2);
            chk("enc_data", 64'(enc_data), 64'(e));
            chk("enc_sel",  64'(enc_block_sel), 64'(lyr));
            q_due.push_back(cyc + 3);
            q_val.push_back(DW'(enc_data + DW'(enc_block_sel) + DW'(1)));
            n_beats++;
        end
        if (flat_valid && !fv_seen) begin
            fv_seen = 1'b1;
            chk("flat_latency", 64'(cyc), 64'(last_rsp + 1));
        end

        enc_out_valid = 1'b0;
        if (inject_next) begin
            enc_out       = 16'hDEAD;
            enc_out_valid = 1'b1;
            inject_next   = 1'b0;
        end else if (q_due.size() > 0 && q_due[0] <= cyc && (!gap || (cyc % 8) < 3)) begin
            enc_out       = q_val.pop_front();
            void'(q_due.pop_front());
            enc_out_valid = 1'b1;
            n_rsp++;
            if (n_rsp == SL * NL) last_rsp = cyc;
            if (inject31 && n_rsp == SL) inject_next = 1'b1;
        end

        in_valid = 1'b0;
        if (loading && load_idx < SL && in_ready && (!gap || (cyc % 3) == 0)) begin
            in_valid = 1'b1;
            in_data  = tok[load_idx];
            load_idx++;
            if (inject_load && load_idx == 10) begin
                enc_out       = 16'hBEEF;
                enc_out_valid = 1'b1;
                inject_load   = 1'b0;
            end
        end
        if (junk_in) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
        end
    endtask

    task automatic run_seq(input bit directed, input bit g, input bit inj31,
                           input bit inj_load, input bit stop_wait);
        bit reached;
        for (int i = 0; i < SL; i++) tok[i] = directed ? DW'(i) : DW'($urandom);
        load_idx = 0; n_beats = 0; n_rsp = 0; last_rsp = -10;
        fv_seen = 1'b0; gap = g; inject31 = inj31; inject_next = 1'b0;
        inject_load = inj_load; loading = 1'b1; reached = 1'b0;
        q_due.delete(); q_val.delete();
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (stop_wait && n_beats == SL * NL && !enc_valid) begin
                reached = 1'b1;
                break;
            end
            if (!stop_wait && fv_seen) break;
        end
        loading = 1'b0;
        if (stop_wait) begin
            chk("reach_wait_l1", 64'(reached), 64'd1);
        end else begin
            chk("flat_valid_seen", 64'(fv_seen), 64'd1);
            chk("enc_beats", 64'(n_beats), 64'(SL * NL));
            chk("enc_results", 64'(n_rsp), 64'(SL * NL));
            chk("flat_valid", 64'(flat_valid), 64'd1);
            check_flat();
        end
    endtask

    task automatic ack_done(input int hold);
        junk_in = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("in_ready_done", 64'(in_ready), 64'd0);
        end
        if (hold > 0) begin
            chk("flat_valid_held", 64'(flat_valid), 64'd1);
            check_flat();
        end
        junk_in  = 1'b0;
        in_valid = 1'b0;
        flat_ack = 1'b1;
        tick();
        flat_ack = 1'b0;
        chk("busy_after_ack", 64'(busy), 64'd0);
        chk("fv_after_ack", 64'(flat_valid), 64'd0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0; enc_out_valid = 1'b0; flat_ack = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outs();
        #1;
        rst = 1'b0;
        loading = 1'b0; inject31 = 1'b0; inject_next = 1'b0; inject_load = 1'b0;
        q_due.delete(); q_val.delete();
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; enc_out = '0;
        enc_out_valid = 1'b0; flat_ack = 1'b0;
        loading = 1'b0; gap = 1'b0; junk_in = 1'b0; fv_seen = 1'b0;
        inject31 = 1'b0; inject_next = 1'b0; inject_load = 1'b0;
        load_idx = 0; n_beats = 0; n_rsp = 0; last_rsp = -10;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs();
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Directed ramp, contiguous traffic
        run_seq(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_clean", 64'(err), 64'd0);
        ack_done(0);

        // Random tokens, gapped input and result traffic, then DONE backpressure
        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ack_done(10);

        // Extra result beat after layer 0 completes
        run_seq(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("err_extra_beat", 64'(err), 64'd1);
        ack_done(0);
        chk("err_sticky", 64'(err), 64'd1);

        // Abort in WAIT of the last layer, then a clean run
        run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_reset();
        tick();
        run_seq(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("err_after_rst_run", 64'(err), 64'd0);
        ack_done(0);

        // Result beat while loading
        run_seq(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("err_load_beat", 64'(err), 64'd1);
        ack_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
